rr_req_queue: RTL and testbench
===============================

Name: rr_req_queue

Overview:
- Two-client request front-end for the two-way round-robin arbiter.
- Each client pushes WIDTH-bit transaction tokens into its own DEPTH-entry FIFO.
- The block drives the arbiter request lines `ir0`/`ir1` whenever the matching FIFO holds data. It consumes the arbiter's `ack0`/`ack1` grants.
- On each grant it pops one token and presents it on a single registered output port tagged with its source.

Parameters:
- WIDTH, 8, token width in bits.
- DEPTH, 4, entries per client FIFO; power of 2, ≥ 2.
- CNT_W, 8, width of the saturating stale-grant counter.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `push0`  in  1  client 0 write strobe.
- `data0`  in  WIDTH  client 0 token.
- `full0`  out  1  FIFO0 holds DEPTH entries.
- `push1`  in  1  client 1 write strobe.
- `data1`  in  WIDTH  client 1 token.
- `full1`  out  1  FIFO1 holds DEPTH entries.
- `ir0`  out  1  request to arbiter, client 0.
- `ir1`  out  1  request to arbiter, client 1.
- `ack0`  in  1  grant from arbiter, client 0.
- `ack1`  in  1  grant from arbiter, client 1.
- `out_valid`  out  1  `out_data` carries a granted token this cycle.
- `out_src`  out  1  0 = token from client 0, 1 = from client 1.
- `out_data`  out  WIDTH  granted token.
- `stale_cnt`  out  CNT_W  saturating count of grants that arrived while the granted FIFO was empty.
- `ovf_err`  out  1  sticky: a push was dropped because its FIFO was full.
- `mutex_err`  out  1  sticky: `ack0` and `ack1` were both high in the same cycle.

Behaviour:
- Reset (sync, `reset`=1 at posedge):
  - Both FIFO counts and pointers := 0.
  - `out_valid`=0, `out_src`=0, `out_data`=0, `stale_cnt`=0, `ovf_err`=0, `mutex_err`=0.
  - `reset` has priority over all other inputs in that cycle. Reset mid-operation discards all queued tokens.
- Per-client FIFO: circular buffer, log2(DEPTH)-bit pointers wrapping modulo DEPTH, count in 0..DEPTH.
- `irN` = (`countN` != 0). It is combinational from the registered count, so it is 0 out of reset. `fullN` = (`countN` == DEPTH).
- Push: if `pushN`=1 and (not `fullN` or a pop of FIFO N occurs in the same cycle), `dataN` is written at the tail and tail advances.
  - Push while full with no same-cycle pop: token dropped, count unchanged, `ovf_err` := 1.
- Pop on grant, evaluated each posedge:
  - `ack0`=1, `ack1`=0, count0 ≠ 0: pop FIFO0 head. Next cycle `out_valid`=1, `out_src`=0, `out_data`=that head.
  - `ack1`=1, `ack0`=0, count1 ≠ 0: symmetric, `out_src`=1.
  - Single ack with the granted FIFO empty: no pop, `out_valid`=0 next cycle, `stale_cnt` += 1, saturating at 2^CNT_W−1. This is expected: arbiter latency is 2 cycles from `ir` to ack, so grants can outlive the queue.
  - `ack0`=`ack1`=1: no pop, `out_valid`=0 next cycle, `mutex_err` := 1.
  - No ack: `out_valid`=0 next cycle; `out_src`/`out_data` hold their previous values.
- Simultaneous push and pop on one FIFO: both take effect, count unchanged. On an empty FIFO the pop cannot occur; only the push takes effect.
- Count update: `countN` += push_accepted − pop_taken. It never exceeds DEPTH or goes below 0.
- Latency:
  - Token pushed at edge k: `irN`=1 from cycle k+1.
  - Ack sampled at edge j: token visible on `out_data` in cycle j+1.
- Sticky flags clear only on `reset`.
- FIFO contents are not reset; only pointers and counts are.

Test Plan:
- Reset then idle 10 cycles -> `ir0`=`ir1`=0, `out_valid`=0, `stale_cnt`=0, both flags 0.
- Push 0xA1, 0xA2 on client 0 only; drive `ack0`=1 for 2 cycles starting 2 cycles later -> `out_data` 0xA1 then 0xA2, `out_src`=0, `ir0` drops after the second pop. A third `ack0` cycle -> `stale_cnt`=1.
- Fill FIFO1 with 4 tokens (DEPTH=4), push a 5th with no ack -> `full1`=1, 5th dropped, `ovf_err`=1. Repeat the 5th push with `ack1`=1 the same cycle -> push accepted, `full1` stays 1.
- Both clients hold 3 tokens; alternate `ack0`/`ack1` each cycle -> output interleaves sources in order 0,1,0,1,0,1 with per-client FIFO order preserved.
- Drive `ack0`=`ack1`=1 for one cycle with both FIFOs non-empty -> no pop, counts unchanged, `mutex_err`=1 and remains 1 until `reset`.
- Assert `reset` with 2 tokens queued and `ack0` high -> next cycle counts 0, `ir0`=0, `out_valid`=0, flags cleared.
- Integration: connect to the arbiter with random pushes -> every pushed token emerges exactly once, per-client order preserved, `mutex_err` never set.

Source files
------------

// File: rtl/rr_req_queue.sv
// ---------------------------------------------------------------------------
// rr_req_queue
//
// Two-client request front-end for a two-way round-robin arbiter. Each client
// pushes WIDTH-bit tokens into its own DEPTH-entry circular FIFO. A non-empty
// FIFO raises its arbiter request line; each grant that lands on a non-empty
// FIFO pops one token, which is presented one cycle later on a registered
// output port tagged with its source client.
//
// Ports
//   clock, reset    : single clock, synchronous active-high reset
//   push0/1         : client write strobes
//   data0/1         : client tokens
//   full0/1         : FIFO holds DEPTH entries
//   ir0/1           : request to arbiter (FIFO non-empty)
//   ack0/1          : grant from arbiter
//   out_valid       : out_data carries a granted token this cycle
//   out_src         : 0 = token from client 0, 1 = from client 1
//   out_data        : granted token (holds when out_valid is low)
//   stale_cnt       : saturating count of grants that found their FIFO empty
//   ovf_err         : sticky, a push was dropped on a full FIFO
//   mutex_err       : sticky, both acks were seen high in the same cycle
// ---------------------------------------------------------------------------
module rr_req_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push0,
  input  logic [WIDTH-1:0] data0,
  output logic             full0,
  input  logic             push1,
  input  logic [WIDTH-1:0] data1,
  output logic             full1,
  output logic             ir0,
  output logic             ir1,
  input  logic             ack0,
  input  logic             ack1,
  output logic             out_valid,
  output logic             out_src,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stale_cnt,
  output logic             ovf_err,
  output logic             mutex_err
);

  // Pointers wrap naturally because DEPTH is a power of two; the count needs
  // one extra bit so it can represent DEPTH itself.
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

  // FIFO storage (not reset; only pointers and counts are)
  logic [WIDTH-1:0] mem0_q [DEPTH];
  logic [WIDTH-1:0] mem1_q [DEPTH];

  // FIFO bookkeeping
  logic [PTR_W-1:0] head0_q, head0_d, tail0_q, tail0_d;
  logic [PTR_W-1:0] head1_q, head1_d, tail1_q, tail1_d;
  logic [OCC_W-1:0] count0_q, count0_d, count1_q, count1_d;

  // Output and status registers
  logic             out_valid_q, out_valid_d;
  logic             out_src_q, out_src_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] stale_q, stale_d;
  logic             ovf_q, ovf_d;
  logic             mutex_q, mutex_d;

  // Decoded per-cycle events
  logic empty0, empty1;
  logic grant0, grant1;
  logic pop0, pop1;
  logic push_acc0, push_acc1;
  logic stale_hit;

  assign empty0 = (count0_q == '0);
  assign empty1 = (count1_q == '0);
  assign full0  = (count0_q == FULL_LVL);
  assign full1  = (count1_q == FULL_LVL);
  assign ir0    = ~empty0;
  assign ir1    = ~empty1;

  // A grant is only honoured when exactly one ack is high; both-high is a
  // protocol error and pops nothing.
  assign grant0 = ack0 & ~ack1;
  assign grant1 = ack1 & ~ack0;
  assign pop0   = grant0 & ~empty0;
  assign pop1   = grant1 & ~empty1;

  // A full FIFO can still take a push when a pop frees a slot the same cycle.
  assign push_acc0 = push0 & (~full0 | pop0);
  assign push_acc1 = push1 & (~full1 | pop1);

  // Grants can outlive the queue because of arbiter latency; count them.
  assign stale_hit = (grant0 & empty0) | (grant1 & empty1);

  // Next-state for the client 0 FIFO pointers and occupancy.
  always_comb begin
    head0_d  = head0_q;
    tail0_d  = tail0_q;
    count0_d = count0_q;
    if (pop0) begin
      head0_d = head0_q + PTR_ONE;
    end
    if (push_acc0) begin
      tail0_d = tail0_q + PTR_ONE;
    end
    if (push_acc0 && !pop0) begin
      count0_d = count0_q + OCC_ONE;
    end else if (pop0 && !push_acc0) begin
      count0_d = count0_q - OCC_ONE;
    end
  end

  // Next-state for the client 1 FIFO pointers and occupancy.
  always_comb begin
    head1_d  = head1_q;
    tail1_d  = tail1_q;
    count1_d = count1_q;
    if (pop1) begin
      head1_d = head1_q + PTR_ONE;
    end
    if (push_acc1) begin
      tail1_d = tail1_q + PTR_ONE;
    end
    if (push_acc1 && !pop1) begin
      count1_d = count1_q + OCC_ONE;
    end else if (pop1 && !push_acc1) begin
      count1_d = count1_q - OCC_ONE;
    end
  end

  // Output port: src/data hold their last value when nothing is popped.
  always_comb begin
    out_valid_d = pop0 | pop1;
    out_src_d   = out_src_q;
    out_data_d  = out_data_q;
    if (pop0) begin
      out_src_d  = 1'b0;
      out_data_d = mem0_q[head0_q];
    end else if (pop1) begin
      out_src_d  = 1'b1;
      out_data_d = mem1_q[head1_q];
    end
  end

  // Status: saturating stale-grant counter and the two sticky error flags.
  always_comb begin
    stale_d = stale_q;
    if (stale_hit && (stale_q != '1)) begin
      stale_d = stale_q + CNT_W'(1);
    end
    ovf_d   = ovf_q | (push0 & ~push_acc0) | (push1 & ~push_acc1);
    mutex_d = mutex_q | (ack0 & ack1);
  end

  // FIFO storage writes; the array is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (!reset && push_acc0) begin
      mem0_q[tail0_q] <= data0;
    end
    if (!reset && push_acc1) begin
      mem1_q[tail1_q] <= data1;
    end
  end

  // Control and output state with synchronous reset taking priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      head0_q     <= '0;
      tail0_q     <= '0;
      count0_q    <= '0;
      head1_q     <= '0;
      tail1_q     <= '0;
      count1_q    <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= 1'b0;
      out_data_q  <= '0;
      stale_q     <= '0;
      ovf_q       <= 1'b0;
      mutex_q     <= 1'b0;
    end else begin
      head0_q     <= head0_d;
      tail0_q     <= tail0_d;
      count0_q    <= count0_d;
      head1_q     <= head1_d;
      tail1_q     <= tail1_d;
      count1_q    <= count1_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      out_data_q  <= out_data_d;
      stale_q     <= stale_d;
      ovf_q       <= ovf_d;
      mutex_q     <= mutex_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign out_data  = out_data_q;
  assign stale_cnt = stale_q;
  assign ovf_err   = ovf_q;
  assign mutex_err = mutex_q;

endmodule

// File: tb/tb_rr_req_queue.sv
// ---------------------------------------------------------------------------
// tb_rr_req_queue
//
// Directed self-checking bench for rr_req_queue (WIDTH=8, DEPTH=4, CNT_W=8).
// Inputs change 1 time unit after a rising edge and outputs are observed at
// that same point, so every observation reflects the edge just taken.
// ---------------------------------------------------------------------------
module tb_rr_req_queue;

  logic       clock;
  logic       reset;
  logic       push0, push1;
  logic [7:0] data0, data1;
  logic       full0, full1;
  logic       ir0, ir1;
  logic       ack0, ack1;
  logic       out_valid, out_src;
  logic [7:0] out_data;
  logic [7:0] stale_cnt;
  logic       ovf_err, mutex_err;

  int total;
  int bad;

  rr_req_queue #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .push0(push0), .data0(data0), .full0(full0),
    .push1(push1), .data1(data1), .full1(full1),
    .ir0(ir0), .ir1(ir1), .ack0(ack0), .ack1(ack1),
    .out_valid(out_valid), .out_src(out_src), .out_data(out_data),
    .stale_cnt(stale_cnt), .ovf_err(ovf_err), .mutex_err(mutex_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    push0 = 1'b0; push1 = 1'b0; ack0 = 1'b0; ack1 = 1'b0;
    data0 = 8'h00; data1 = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Reset followed by ten idle cycles.
  task automatic test_reset();
    do_reset();
    repeat (10) step();
    total++; if (ir0 !== 1'b0) begin bad++; $display("FAIL reset_ir0: got %b want 0", ir0); end
    total++; if (ir1 !== 1'b0) begin bad++; $display("FAIL reset_ir1: got %b want 0", ir1); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", out_data); end
    total++; if (stale_cnt !== 8'd0) begin bad++; $display("FAIL reset_stale: got %0d want 0", stale_cnt); end
    total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf_err); end
    total++; if (mutex_err !== 1'b0) begin bad++; $display("FAIL reset_mutex: got %b want 0", mutex_err); end
    total++; if (full0 !== 1'b0 || full1 !== 1'b0) begin bad++; $display("FAIL reset_full: got %b%b want 00", full0, full1); end
  endtask

  // Client 0 push then grant, plus a stale grant afterwards.
  task automatic test_client0();
    push0 = 1'b1; data0 = 8'hA1;
    step();
    total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL c0_ir_after_push: got %b want 1", ir0); end
    data0 = 8'hA2;
    step();
    push0 = 1'b0;
    step();
    step();
    ack0 = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 8'hA1) begin bad++;
      $display("FAIL c0_first: got v=%b s=%b d=%h want v=1 s=0 d=a1", out_valid, out_src, out_data); end
    total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL c0_ir_mid: got %b want 1", ir0); end
    step();
    total++; if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 8'hA2) begin bad++;
      $display("FAIL c0_second: got v=%b s=%b d=%h want v=1 s=0 d=a2", out_valid, out_src, out_data); end
    total++; if (ir0 !== 1'b0) begin bad++; $display("FAIL c0_ir_drop: got %b want 0", ir0); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL c0_stale_valid: got %b want 0", out_valid); end
    total++; if (stale_cnt !== 8'd1) begin bad++; $display("FAIL c0_stale_cnt: got %0d want 1", stale_cnt); end
    ack0 = 1'b0;
    step();
    total++; if (out_data !== 8'hA2 || out_src !== 1'b0) begin bad++;
      $display("FAIL c0_hold: got s=%b d=%h want s=0 d=a2", out_src, out_data); end
  endtask

  // Fill FIFO1, overflow it, then push into a full FIFO while popping.
  task automatic test_overflow();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'hB1; exp_seq[1] = 8'hB2; exp_seq[2] = 8'hB3; exp_seq[3] = 8'hB5;
    do_reset();
    push1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data1 = 8'hB0 + 8'(i);
      step();
    end
    total++; if (full1 !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b want 1", full1); end
    total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", ovf_err); end
    data1 = 8'hB4;
    step();
    total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", ovf_err); end
    total++; if (full1 !== 1'b1) begin bad++; $display("FAIL ovf_full_hold: got %b want 1", full1); end
    data1 = 8'hB5; ack1 = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_src !== 1'b1 || out_data !== 8'hB0) begin bad++;
      $display("FAIL ovf_pop_push: got v=%b s=%b d=%h want v=1 s=1 d=b0", out_valid, out_src, out_data); end
    total++; if (full1 !== 1'b1) begin bad++; $display("FAIL ovf_full_after_pp: got %b want 1", full1); end
    push1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (out_valid !== 1'b1 || out_src !== 1'b1 || out_data !== exp_seq[i]) begin bad++;
        $display("FAIL ovf_drain%0d: got v=%b s=%b d=%h want v=1 s=1 d=%h", i, out_valid, out_src, out_data, exp_seq[i]); end
    end
    ack1 = 1'b0;
    total++; if (ir1 !== 1'b0 || full1 !== 1'b0) begin bad++; $display("FAIL ovf_empty: got ir=%b full=%b want 0 0", ir1, full1); end
    total++; if (stale_cnt !== 8'd0) begin bad++; $display("FAIL ovf_stale: got %0d want 0", stale_cnt); end
  endtask

  // Both clients hold three tokens; alternate grants between them.
  task automatic test_interleave();
    logic [7:0] exp_d [6];
    exp_d[0] = 8'hC0; exp_d[1] = 8'hD0; exp_d[2] = 8'hC1;
    exp_d[3] = 8'hD1; exp_d[4] = 8'hC2; exp_d[5] = 8'hD2;
    do_reset();
    push0 = 1'b1; push1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data0 = 8'hC0 + 8'(i);
      data1 = 8'hD0 + 8'(i);
      step();
    end
    push0 = 1'b0; push1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ack0 = (i % 2 == 0);
      ack1 = (i % 2 == 1);
      step();
      total++; if (out_valid !== 1'b1 || out_src !== 1'(i % 2) || out_data !== exp_d[i]) begin bad++;
        $display("FAIL ilv%0d: got v=%b s=%b d=%h want v=1 s=%0d d=%h", i, out_valid, out_src, out_data, i % 2, exp_d[i]); end
    end
    ack0 = 1'b0; ack1 = 1'b0;
    total++; if (ir0 !== 1'b0 || ir1 !== 1'b0) begin bad++; $display("FAIL ilv_empty: got %b%b want 00", ir0, ir1); end
  endtask

  // Reset arriving with tokens queued and a grant pending.
  task automatic test_reset_mid();
    push0 = 1'b1; data0 = 8'hE0;
    step();
    data0 = 8'hE1;
    step();
    push0 = 1'b0; ack0 = 1'b1; ack1 = 1'b1;
    step();
    total++; if (mutex_err !== 1'b1) begin bad++; $display("FAIL mid_pre_mutex: got %b want 1", mutex_err); end
    ack1 = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (ir0 !== 1'b0 || out_valid !== 1'b0) begin bad++;
      $display("FAIL mid_reset_state: got ir0=%b v=%b want 0 0", ir0, out_valid); end
    total++; if (mutex_err !== 1'b0 || ovf_err !== 1'b0 || stale_cnt !== 8'd0) begin bad++;
      $display("FAIL mid_reset_flags: got m=%b o=%b s=%0d want 0 0 0", mutex_err, ovf_err, stale_cnt); end
    step();
    total++; if (out_valid !== 1'b0 || stale_cnt !== 8'd1) begin bad++;
      $display("FAIL mid_discard: got v=%b stale=%0d want 0 1", out_valid, stale_cnt); end
    ack0 = 1'b0;
  endtask

  // Push into an empty FIFO under a grant, then push and pop together.
  task automatic test_back_to_back();
    push0 = 1'b1; data0 = 8'h51; ack0 = 1'b1;
    step();
    total++; if (ir0 !== 1'b1 || out_valid !== 1'b0 || stale_cnt !== 8'd2) begin bad++;
      $display("FAIL b2b_empty: got ir0=%b v=%b stale=%0d want 1 0 2", ir0, out_valid, stale_cnt); end
    data0 = 8'h52;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h51 || ir0 !== 1'b1) begin bad++;
      $display("FAIL b2b_pp: got v=%b d=%h ir0=%b want 1 51 1", out_valid, out_data, ir0); end
    push0 = 1'b0;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h52 || ir0 !== 1'b0) begin bad++;
      $display("FAIL b2b_last: got v=%b d=%h ir0=%b want 1 52 0", out_valid, out_data, ir0); end
    ack0 = 1'b0;
  endtask

  // Both acks together: nothing pops and the sticky flag stays set.
  task automatic test_mutex();
    do_reset();
    push0 = 1'b1; data0 = 8'h61; push1 = 1'b1; data1 = 8'h71;
    step();
    push0 = 1'b0; push1 = 1'b0; ack0 = 1'b1; ack1 = 1'b1;
    step();
    ack0 = 1'b0; ack1 = 1'b0;
    total++; if (mutex_err !== 1'b1 || out_valid !== 1'b0) begin bad++;
      $display("FAIL mutex_set: got m=%b v=%b want 1 0", mutex_err, out_valid); end
    total++; if (stale_cnt !== 8'd0) begin bad++; $display("FAIL mutex_stale: got %0d want 0", stale_cnt); end
    repeat (3) step();
    total++; if (mutex_err !== 1'b1) begin bad++; $display("FAIL mutex_sticky: got %b want 1", mutex_err); end
    ack0 = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 8'h61 || ir0 !== 1'b0) begin bad++;
      $display("FAIL mutex_kept0: got v=%b s=%b d=%h ir0=%b want 1 0 61 0", out_valid, out_src, out_data, ir0); end
    ack0 = 1'b0; ack1 = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_src !== 1'b1 || out_data !== 8'h71 || ir1 !== 1'b0) begin bad++;
      $display("FAIL mutex_kept1: got v=%b s=%b d=%h ir1=%b want 1 1 71 0", out_valid, out_src, out_data, ir1); end
    ack1 = 1'b0;
  endtask

  // Stale-grant counter saturates at its maximum.
  task automatic test_stale_sat();
    do_reset();
    ack1 = 1'b1;
    repeat (100) step();
    total++; if (stale_cnt !== 8'd100) begin bad++; $display("FAIL stale_100: got %0d want 100", stale_cnt); end
    repeat (160) step();
    total++; if (stale_cnt !== 8'd255) begin bad++; $display("FAIL stale_sat: got %0d want 255", stale_cnt); end
    ack1 = 1'b0;
  endtask

  // Random pushes with a simple one-grant-at-a-time round-robin granter;
  // every token must come out once, in per-client order.
  task automatic test_random_flow();
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] exp_data;
    logic       exp_valid, exp_src, turn;
    do_reset();
    turn = 1'b0;
    for (int cyc = 0; cyc < 340; cyc++) begin
      idle_inputs();
      exp_valid = 1'b0; exp_src = 1'b0; exp_data = 8'h00;
      if (cyc < 300) begin
        if (!full0 && $urandom_range(0, 1) == 1) begin
          push0 = 1'b1; data0 = 8'($urandom); q0.push_back(data0);
        end
        if (!full1 && $urandom_range(0, 2) != 0) begin
          push1 = 1'b1; data1 = 8'($urandom); q1.push_back(data1);
        end
      end
      if ($urandom_range(0, 3) != 0 && (ir0 || ir1)) begin
        exp_src = (ir0 && ir1) ? turn : ir1;
        turn = ~exp_src;
        exp_valid = 1'b1;
        if (exp_src) begin ack1 = 1'b1; exp_data = q1.pop_front(); end
        else begin ack0 = 1'b1; exp_data = q0.pop_front(); end
      end
      step();
      total++; if (out_valid !== exp_valid || (exp_valid && (out_src !== exp_src || out_data !== exp_data))) begin bad++;
        $display("FAIL rnd_c%0d: got v=%b s=%b d=%h want v=%b s=%b d=%h", cyc, out_valid, out_src, out_data, exp_valid, exp_src, exp_data); end
    end
    idle_inputs();
    total++; if (q0.size() != 0 || q1.size() != 0 || ir0 !== 1'b0 || ir1 !== 1'b0) begin bad++;
      $display("FAIL rnd_drain: got q0=%0d q1=%0d ir=%b%b want 0 0 00", q0.size(), q1.size(), ir0, ir1); end
    total++; if (mutex_err !== 1'b0 || ovf_err !== 1'b0) begin bad++;
      $display("FAIL rnd_flags: got m=%b o=%b want 0 0", mutex_err, ovf_err); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_client0();
    test_overflow();
    test_interleave();
    test_reset_mid();
    test_back_to_back();
    test_mutex();
    test_stale_sat();
    test_random_flow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
